// File: rtl/ff_fifo_sched_if.sv
// Handshake bundle between the ff_fifo_sched scheduler, the Y/Cb/Cr FIFOs and the packer.
// master = scheduler side, slave = FIFO/packer environment side.
interface ff_fifo_sched_if #(
  parameter int DATA_W = 91,
  parameter int MCU_W  = 16
);

  logic                  en;
  logic [2:0]            fifo_empty;
  logic [2:0]            read_req;
  logic [3*DATA_W-1:0]   read_data;
  logic [2:0]            rdata_valid;
  logic [DATA_W-2:0]     out_data;
  logic                  out_eob;
  logic [1:0]            out_chan;
  logic                  out_valid;
  logic                  out_ready;
  logic [MCU_W-1:0]      mcu_count;
  logic                  protocol_err;
  logic [47:0]           word_cnt;

  modport master (
    input  en, fifo_empty, read_data, rdata_valid, out_ready,
    output read_req, out_data, out_eob, out_chan, out_valid,
           mcu_count, protocol_err, word_cnt
  );

  modport slave (
    output en, fifo_empty, read_data, rdata_valid, out_ready,
    input  read_req, out_data, out_eob, out_chan, out_valid,
           mcu_count, protocol_err, word_cnt
  );

endinterface

// File: rtl/ff_fifo_sched.sv
// Round-robin Y/Cb/Cr FIFO drain sequencer with a single valid/ready output register.
// Optional per-channel word counters enabled by defining FF_FIFO_SCHED_WORD_CNT_EN.
module ff_fifo_sched #(
  parameter int DATA_W = 91,
  parameter int MCU_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  ff_fifo_sched_if.master   bus
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         ch_q, ch_d;
  logic [2:0]         read_req_q, read_req_d;
  logic [DATA_W-2:0]  out_data_q, out_data_d;
  logic               out_eob_q, out_eob_d;
  logic [1:0]         out_chan_q, out_chan_d;
  logic               out_valid_q, out_valid_d;
  logic [MCU_W-1:0]   mcu_count_q, mcu_count_d;
  logic               protocol_err_q, protocol_err_d;
  logic               err_mask_q;

  logic [2:0]         ch_onehot;
  logic [DATA_W-1:0]  word_ch;
  logic               empty_ch;
  logic               rdv_ch;
  logic               multi_hit;
  logic               stray_hit;
  logic               idle_hit;
  logic               accept;

  // Per-channel views selected by the current channel pointer.
  always_comb begin
    ch_onehot = 3'b001;
    word_ch   = bus.read_data[DATA_W-1:0];
    empty_ch  = bus.fifo_empty[0];
    rdv_ch    = bus.rdata_valid[0];
    case (ch_q)
      2'd1: begin
        ch_onehot = 3'b010;
        word_ch   = bus.read_data[2*DATA_W-1:DATA_W];
        empty_ch  = bus.fifo_empty[1];
        rdv_ch    = bus.rdata_valid[1];
      end
      2'd2: begin
        ch_onehot = 3'b100;
        word_ch   = bus.read_data[3*DATA_W-1:2*DATA_W];
        empty_ch  = bus.fifo_empty[2];
        rdv_ch    = bus.rdata_valid[2];
      end
      default: begin
        ch_onehot = 3'b001;
        word_ch   = bus.read_data[DATA_W-1:0];
        empty_ch  = bus.fifo_empty[0];
        rdv_ch    = bus.rdata_valid[0];
      end
    endcase
  end

  assign multi_hit = (bus.rdata_valid[0] & bus.rdata_valid[1]) |
                     (bus.rdata_valid[0] & bus.rdata_valid[2]) |
                     (bus.rdata_valid[1] & bus.rdata_valid[2]);
  assign stray_hit = |(bus.rdata_valid & ~ch_onehot);
  assign idle_hit  = (|bus.rdata_valid) && (state_q != WAIT);
  assign accept    = out_valid_q && bus.out_ready;

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    read_req_d     = 3'b000;
    out_data_d     = out_data_q;
    out_eob_d      = out_eob_q;
    out_chan_d     = out_chan_q;
    out_valid_d    = out_valid_q;
    mcu_count_d    = mcu_count_q;
    // The post-reset mask hides the late rdata_valid of a read dropped by reset.
    protocol_err_d = protocol_err_q | (!err_mask_q && (multi_hit || stray_hit || idle_hit));

    case (state_q)
      ISSUE: begin
        if (bus.en && !empty_ch) begin
          read_req_d = ch_onehot;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (rdv_ch) begin
          out_data_d  = word_ch[DATA_W-2:0];
          out_eob_d   = word_ch[DATA_W-1];
          out_chan_d  = ch_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          out_valid_d = 1'b0;
          state_d     = ISSUE;
          if (out_eob_q) begin
            if (ch_q == 2'd2) begin
              ch_d        = 2'd0;
              mcu_count_d = mcu_count_q + MCU_W'(1);
            end else begin
              ch_d = ch_q + 2'd1;
            end
          end
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ISSUE;
      ch_q           <= 2'd0;
      read_req_q     <= 3'b000;
      out_data_q     <= '0;
      out_eob_q      <= 1'b0;
      out_chan_q     <= 2'd0;
      out_valid_q    <= 1'b0;
      mcu_count_q    <= '0;
      protocol_err_q <= 1'b0;
      err_mask_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      read_req_q     <= read_req_d;
      out_data_q     <= out_data_d;
      out_eob_q      <= out_eob_d;
      out_chan_q     <= out_chan_d;
      out_valid_q    <= out_valid_d;
      mcu_count_q    <= mcu_count_d;
      protocol_err_q <= protocol_err_d;
      err_mask_q     <= 1'b0;
    end
  end

  assign bus.read_req     = read_req_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_eob      = out_eob_q;
  assign bus.out_chan     = out_chan_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.mcu_count    = mcu_count_q;
  assign bus.protocol_err = protocol_err_q;

`ifdef FF_FIFO_SCHED_WORD_CNT_EN
  logic [15:0] wc_y_q, wc_cb_q, wc_cr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wc_y_q  <= 16'd0;
      wc_cb_q <= 16'd0;
      wc_cr_q <= 16'd0;
    end else if (accept) begin
      case (out_chan_q)
        2'd0:    wc_y_q  <= wc_y_q + 16'd1;
        2'd1:    wc_cb_q <= wc_cb_q + 16'd1;
        2'd2:    wc_cr_q <= wc_cr_q + 16'd1;
        default: wc_y_q  <= wc_y_q;
      endcase
    end
  end

  assign bus.word_cnt = {wc_cr_q, wc_cb_q, wc_y_q};
`else
  assign bus.word_cnt = 48'd0;
`endif

endmodule

// File: tb/tb_ff_fifo_sched.sv
// Directed scoreboard bench for ff_fifo_sched: FIFO model, expected-word queue, immediate assertions.
module tb_ff_fifo_sched;

  localparam int DATA_W = 91;
  localparam int MCU_W  = 16;

  typedef struct {
    logic [1:0]        ch;
    logic              eob;
    logic [DATA_W-2:0] data;
  } exp_t;

  logic clk;
  logic rst;

  ff_fifo_sched_if #(.DATA_W(DATA_W), .MCU_W(MCU_W)) bus ();

  ff_fifo_sched #(.DATA_W(DATA_W), .MCU_W(MCU_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DATA_W-1:0]   fifoQ0[$];
  logic [DATA_W-1:0]   fifoQ1[$];
  logic [DATA_W-1:0]   fifoQ2[$];
  exp_t                expQ[$];
  logic [2:0]          mdlRv    = 3'b000;
  logic [2:0]          injRv    = 3'b000;
  logic [2:0]          mdlEmpty = 3'b111;
  logic [3*DATA_W-1:0] mdlData  = '0;

  int checkCount = 0;
  int passCount  = 0;

  assign bus.fifo_empty  = mdlEmpty;
  assign bus.read_data   = mdlData;
  assign bus.rdata_valid = mdlRv | injRv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: a registered read returns its word with rdata_valid one cycle later.
  always @(posedge clk) begin
    mdlRv <= 3'b000;
    if (bus.read_req[0] && fifoQ0.size() > 0) begin
      mdlData[DATA_W-1:0] <= fifoQ0.pop_front();
      mdlRv[0] <= 1'b1;
    end
    if (bus.read_req[1] && fifoQ1.size() > 0) begin
      mdlData[2*DATA_W-1:DATA_W] <= fifoQ1.pop_front();
      mdlRv[1] <= 1'b1;
    end
    if (bus.read_req[2] && fifoQ2.size() > 0) begin
      mdlData[3*DATA_W-1:2*DATA_W] <= fifoQ2.pop_front();
      mdlRv[2] <= 1'b1;
    end
    mdlEmpty <= {fifoQ2.size() == 0, fifoQ1.size() == 0, fifoQ0.size() == 0};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DATA_W-2:0] randPayload();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DATA_W-2:0];
  endfunction

  // Loads one word into a channel FIFO; scoreboarded words are also queued as expected output.
  task automatic applyStimulus(input logic [1:0] ch, input logic eob, input logic scored);
    logic [DATA_W-2:0] p;
    exp_t e;
    p = randPayload();
    case (ch)
      2'd0:    fifoQ0.push_back({eob, p});
      2'd1:    fifoQ1.push_back({eob, p});
      default: fifoQ2.push_back({eob, p});
    endcase
    if (scored) begin
      e.ch = ch;
      e.eob = eob;
      e.data = p;
      expQ.push_back(e);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".read_req"},     bus.read_req, 3'b000);
    checkOutput({tag, ".out_data"},     bus.out_data, '0);
    checkOutput({tag, ".out_eob"},      bus.out_eob, 1'b0);
    checkOutput({tag, ".out_chan"},     bus.out_chan, 2'd0);
    checkOutput({tag, ".out_valid"},    bus.out_valid, 1'b0);
    checkOutput({tag, ".mcu_count"},    bus.mcu_count, '0);
    checkOutput({tag, ".protocol_err"}, bus.protocol_err, 1'b0);
    checkOutput({tag, ".word_cnt"},     bus.word_cnt, 48'd0);
  endtask

  // Pops and compares every accepted word; also polices read_req shape while draining.
  task automatic drainExpected(input int budget);
    exp_t e;
    int cyc = 0;
    int badReq = 0;
    logic [2:0] prevReq = 3'b000;
    while (expQ.size() > 0 && cyc < budget) begin
      if ((bus.read_req & (bus.read_req - 3'd1)) != 3'b000) badReq++;
      if (bus.read_req != 3'b000 && prevReq != 3'b000) badReq++;
      if (bus.read_req != 3'b000 && bus.out_valid) badReq++;
      prevReq = bus.read_req;
      if (bus.out_valid && bus.out_ready) begin
        e = expQ.pop_front();
        checkOutput("word.chan", bus.out_chan, e.ch);
        checkOutput("word.eob",  bus.out_eob,  e.eob);
        checkOutput("word.data", bus.out_data, e.data);
      end
      tick();
      cyc++;
    end
    checkOutput("drain.leftover", expQ.size(), 0);
    checkOutput("drain.readReqShape", badReq, 0);
  endtask

  task automatic waitReadReq(input int chIdx, input int budget);
    int cyc = 0;
    while (!bus.read_req[chIdx] && cyc < budget) begin
      tick();
      cyc++;
    end
    checkOutput("waitReadReq.timeout", (cyc >= budget), 1'b0);
  endtask

  initial begin
    int hold;
    int reqSeen;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    rst = 1'b0;

    // All FIFOs empty: the scheduler must sit in ISSUE.
    bus.en = 1'b1;
    reqSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.read_req != 3'b000 || bus.out_valid) reqSeen++;
    end
    checkOutput("empty.activity", reqSeen, 0);
    checkOutput("empty.mcu", bus.mcu_count, '0);

    // One full MCU: Y,Y(eob),Cb(eob),Cr(eob).
    bus.out_ready = 1'b1;
    applyStimulus(2'd0, 1'b0, 1'b1);
    applyStimulus(2'd0, 1'b1, 1'b1);
    applyStimulus(2'd1, 1'b1, 1'b1);
    applyStimulus(2'd2, 1'b1, 1'b1);
    drainExpected(200);
    tick();
    checkOutput("mcu1.count", bus.mcu_count, 16'd1);
    checkOutput("mcu1.err", bus.protocol_err, 1'b0);

    // Backpressure: word must stay stable and no further read may issue.
    bus.out_ready = 1'b0;
    applyStimulus(2'd0, 1'b0, 1'b1);
    hold = 0;
    while (!bus.out_valid && hold < 50) begin
      tick();
      hold++;
    end
    checkOutput("hold.validTimeout", (hold >= 50), 1'b0);
    reqSeen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.read_req != 3'b000) reqSeen++;
      if (!bus.out_valid || bus.out_data !== expQ[0].data ||
          bus.out_eob !== expQ[0].eob || bus.out_chan !== expQ[0].ch) reqSeen++;
    end
    checkOutput("hold.stable", reqSeen, 0);
    bus.out_ready = 1'b1;
    drainExpected(20);
    checkOutput("hold.singleAccept", bus.out_valid, 1'b0);

    // Stray rdata_valid[2] while waiting on Y flags an error but the Y word still lands.
    applyStimulus(2'd0, 1'b1, 1'b1);
    waitReadReq(0, 50);
    injRv = 3'b100;
    tick();
    injRv = 3'b000;
    checkOutput("inject.err", bus.protocol_err, 1'b1);
    drainExpected(50);
    applyStimulus(2'd1, 1'b1, 1'b1);
    applyStimulus(2'd2, 1'b1, 1'b1);
    drainExpected(100);
    tick();
    checkOutput("inject.mcu", bus.mcu_count, 16'd2);
    checkOutput("inject.errSticky", bus.protocol_err, 1'b1);

    // Reset during an in-flight read: the late rdata_valid is masked.
    applyStimulus(2'd0, 1'b0, 1'b0);
    waitReadReq(0, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checkResetValues("midReset");
    reqSeen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid || bus.protocol_err || bus.read_req != 3'b000) reqSeen++;
    end
    checkOutput("midReset.quiet", reqSeen, 0);

    // Word counters: 3 Y, 2 Cb, 1 Cr.
    applyStimulus(2'd0, 1'b0, 1'b1);
    applyStimulus(2'd0, 1'b0, 1'b1);
    applyStimulus(2'd0, 1'b1, 1'b1);
    applyStimulus(2'd1, 1'b0, 1'b1);
    applyStimulus(2'd1, 1'b1, 1'b1);
    applyStimulus(2'd2, 1'b1, 1'b1);
    drainExpected(300);
    tick();
`ifdef FF_FIFO_SCHED_WORD_CNT_EN
    checkOutput("wordCnt", bus.word_cnt, 48'h0001_0002_0003);
`else
    checkOutput("wordCnt", bus.word_cnt, 48'h0);
`endif
    checkOutput("wordCnt.mcu", bus.mcu_count, 16'd1);
    checkOutput("wordCnt.err", bus.protocol_err, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
